// File: rtl/traffic_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_lamp_monitor
// Brief    : Online safety checker for red/yellow/green traffic lamp outputs.
//            Decodes the lamps into phases, measures run lengths, and flags
//            conflicts, illegal sequences, bad durations and overlong darkness.
// Revision : 1.0  initial release
// ============================================================================
module traffic_lamp_monitor #(
    parameter int PERIOD       = 10,
    parameter int BLINK_PERIOD = 5,
    parameter int TOL          = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             day,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr_fault,
    output logic [1:0]       phase,
    output logic             phase_done,
    output logic [CNT_W-1:0] phase_len,
    output logic             seq_err,
    output logic             timing_err,
    output logic             conflict_err,
    output logic             fault
);

    localparam logic [1:0] C_PH_RED  = 2'b00;
    localparam logic [1:0] C_PH_YEL  = 2'b01;
    localparam logic [1:0] C_PH_GRN  = 2'b10;
    localparam logic [1:0] C_PH_DARK = 2'b11;

    localparam logic [CNT_W-1:0] C_DAY_LO   = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] C_DAY_HI   = CNT_W'(PERIOD + TOL);
    localparam logic [CNT_W-1:0] C_NIGHT_LO = CNT_W'(BLINK_PERIOD - TOL);
    localparam logic [CNT_W-1:0] C_NIGHT_HI = CNT_W'(BLINK_PERIOD + TOL);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,
        ST_DAY_TRK   = 2'd1,
        ST_NIGHT_TRK = 2'd2
    } state_t;

    // Stage 1: input capture
    logic [2:0] lamps_q;
    logic       day_q;
    logic       day_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lamps_q    <= 3'b000;
            day_q      <= 1'b0;
            day_prev_q <= 1'b0;
        end else begin
            lamps_q    <= {red, yellow, green};
            day_q      <= day;
            day_prev_q <= day_q;
        end
    end

    // Stage 2: decode, run measurement and checking FSM
    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             seq_q, seq_d;
    logic             tim_q, tim_d;
    logic             conf_q, conf_d;
    logic             fault_q, fault_d;
    logic             dark_flag_q, dark_flag_d;
    logic             in_conf_q, in_conf_d;

    logic [1:0]       w_code;
    logic             w_conflict;
    logic             w_toggle;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_day_legal;
    logic             w_night_legal;

    function automatic logic out_of_window(input logic [CNT_W-1:0] len,
                                           input logic [CNT_W-1:0] lo,
                                           input logic [CNT_W-1:0] hi);
        return (len == {CNT_W{1'b1}}) || (len < lo) || (len > hi);
    endfunction

    always_comb begin
        w_conflict = 1'b0;
        w_code     = C_PH_DARK;
        case (lamps_q)
            3'b100:  w_code = C_PH_RED;
            3'b010:  w_code = C_PH_YEL;
            3'b001:  w_code = C_PH_GRN;
            3'b000:  w_code = C_PH_DARK;
            default: w_conflict = 1'b1;
        endcase
    end

    assign w_toggle  = day_q ^ day_prev_q;
    assign w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + C_CNT_ONE;

    assign w_day_legal = ((phase_q == C_PH_DARK) && (w_code == C_PH_RED)) ||
                         ((phase_q == C_PH_RED)  && (w_code == C_PH_GRN)) ||
                         ((phase_q == C_PH_GRN)  && (w_code == C_PH_YEL)) ||
                         ((phase_q == C_PH_YEL)  && (w_code == C_PH_RED));

    assign w_night_legal = ((phase_q == C_PH_YEL) || (phase_q == C_PH_DARK)) &&
                           ((w_code  == C_PH_YEL) || (w_code  == C_PH_DARK));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        done_d      = 1'b0;
        seq_d       = 1'b0;
        tim_d       = 1'b0;
        conf_d      = 1'b0;
        dark_flag_d = dark_flag_q;
        in_conf_d   = in_conf_q;

        if (w_conflict) begin
            // Phase and counter freeze while the lamps are in conflict.
            conf_d    = 1'b1;
            in_conf_d = 1'b1;
            state_d   = ST_SYNC;
        end else if (in_conf_q) begin
            // Recovery: a fresh run begins, left untimed by staying in SYNC.
            in_conf_d   = 1'b0;
            state_d     = ST_SYNC;
            dark_flag_d = 1'b0;
            cnt_d       = C_CNT_ONE;
            phase_d     = w_code;
            if (w_code != phase_q) begin
                done_d = 1'b1;
                len_d  = cnt_q;
            end
        end else if (w_code != phase_q) begin
            done_d      = 1'b1;
            len_d       = cnt_q;
            phase_d     = w_code;
            cnt_d       = C_CNT_ONE;
            dark_flag_d = 1'b0;
            if (w_toggle) begin
                state_d = ST_SYNC;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        state_d = day_q ? ST_DAY_TRK : ST_NIGHT_TRK;
                    end
                    ST_DAY_TRK: begin
                        seq_d = ~w_day_legal;
                        if (phase_q != C_PH_DARK) begin
                            tim_d = out_of_window(cnt_q, C_DAY_LO, C_DAY_HI);
                        end
                        if (seq_d || tim_d) begin
                            state_d = ST_SYNC;
                        end
                    end
                    ST_NIGHT_TRK: begin
                        seq_d = ~w_night_legal;
                        tim_d = out_of_window(cnt_q, C_NIGHT_LO, C_NIGHT_HI);
                        if (seq_d || tim_d) begin
                            state_d = ST_SYNC;
                        end
                    end
                    default: begin
                        state_d = ST_SYNC;
                    end
                endcase
            end
        end else begin
            cnt_d = w_cnt_inc;
            if (w_toggle) begin
                state_d = ST_SYNC;
            end else if ((state_q == ST_DAY_TRK) && (phase_q == C_PH_DARK) &&
                         !dark_flag_q && (w_cnt_inc > C_DAY_HI)) begin
                tim_d       = 1'b1;
                dark_flag_d = 1'b1;
            end
        end
    end

    // An error in the same cycle as clr_fault wins, keeping the fault set.
    always_comb begin
        fault_d = clr_fault ? 1'b0 : fault_q;
        if (seq_d || tim_d || conf_d) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SYNC;
            phase_q     <= C_PH_DARK;
            cnt_q       <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
            seq_q       <= 1'b0;
            tim_q       <= 1'b0;
            conf_q      <= 1'b0;
            fault_q     <= 1'b0;
            dark_flag_q <= 1'b0;
            in_conf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            done_q      <= done_d;
            seq_q       <= seq_d;
            tim_q       <= tim_d;
            conf_q      <= conf_d;
            fault_q     <= fault_d;
            dark_flag_q <= dark_flag_d;
            in_conf_q   <= in_conf_d;
        end
    end

    assign phase        = phase_q;
    assign phase_done   = done_q;
    assign phase_len    = len_q;
    assign seq_err      = seq_q;
    assign timing_err   = tim_q;
    assign conflict_err = conf_q;
    assign fault        = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_lamp_monitor
// Brief    : Directed self-checking bench for traffic_lamp_monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_lamp_monitor;

    localparam logic [2:0] C_R  = 3'b100;
    localparam logic [2:0] C_Y  = 3'b010;
    localparam logic [2:0] C_G  = 3'b001;
    localparam logic [2:0] C_D  = 3'b000;
    localparam logic [2:0] C_RG = 3'b101;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       day;
    logic       red, yellow, green;
    logic       clr_fault;
    logic [1:0] phase;
    logic       phase_done;
    logic [7:0] phase_len;
    logic       seq_err, timing_err, conflict_err, fault;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_seq   = 0;
    int n_tim   = 0;
    int n_conf  = 0;
    int s_seq, s_tim, s_conf, s_done;
    int lens[$];

    traffic_lamp_monitor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .day          (day),
        .red          (red),
        .yellow       (yellow),
        .green        (green),
        .clr_fault    (clr_fault),
        .phase        (phase),
        .phase_done   (phase_done),
        .phase_len    (phase_len),
        .seq_err      (seq_err),
        .timing_err   (timing_err),
        .conflict_err (conflict_err),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (phase_done) begin
                n_done++;
                lens.push_back(int'(phase_len));
            end
            if (seq_err)      n_seq++;
            if (timing_err)   n_tim++;
            if (conflict_err) n_conf++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic [2:0] l, input int n);
        {red, yellow, green} = l;
        tick(n);
    endtask

    task automatic snap();
        s_seq  = n_seq;
        s_tim  = n_tim;
        s_conf = n_conf;
        s_done = n_done;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        day = 1'b0;
        {red, yellow, green} = C_D;
        clr_fault = 1'b0;
        tick(2);
        reset_n = 1'b1;

        // T1: async reset mid-run clears everything immediately
        hold(C_RG, 1);
        hold(C_Y, 4);
        check("t1_fault_before_reset", fault, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t1_phase_rst", phase, 2'b11);
        check("t1_fault_rst", fault, 0);
        check("t1_len_rst", phase_len, 0);
        check("t1_pulses_rst", {phase_done, seq_err, timing_err, conflict_err}, 0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        tick(1);
        check("t1_phase_hold", phase, 2'b11);
        check("t1_done_hold", phase_done, 0);
        tick(1);
        check("t1_phase_yellow", phase, 2'b01);

        // T2: clean day cycle
        reset_n = 1'b0;
        day = 1'b1;
        {red, yellow, green} = C_D;
        tick(2);
        reset_n = 1'b1;
        snap();
        lens.delete();
        hold(C_D, 10);
        hold(C_R, 10);
        hold(C_G, 10);
        hold(C_Y, 10);
        hold(C_R, 10);
        check("t2_done_cnt", n_done - s_done, 4);
        check("t2_len_rg", lens[1], 10);
        check("t2_len_gy", lens[2], 10);
        check("t2_len_yr", lens[3], 10);
        check("t2_seq_cnt", n_seq - s_seq, 0);
        check("t2_tim_cnt", n_tim - s_tim, 0);
        check("t2_fault", fault, 0);

        // T3: illegal RED->YELLOW, then clear fault
        {red, yellow, green} = C_Y;
        tick(2);
        check("t3_seq", seq_err, 1);
        check("t3_tim", timing_err, 0);
        check("t3_done", phase_done, 1);
        check("t3_len", phase_len, 10);
        check("t3_fault", fault, 1);
        tick(1);
        check("t3_seq_pulse_end", seq_err, 0);
        clr_fault = 1'b1;
        tick(1);
        clr_fault = 1'b0;
        check("t3_fault_clr", fault, 0);

        // T4: timing window boundaries on GREEN
        hold(C_Y, 6);
        hold(C_R, 10);
        hold(C_G, 13);
        {red, yellow, green} = C_Y;
        tick(2);
        check("t4_tim_g13", timing_err, 1);
        check("t4_done_g13", phase_done, 1);
        check("t4_len_g13", phase_len, 13);
        check("t4_seq_g13", seq_err, 0);
        snap();
        hold(C_Y, 8);
        hold(C_R, 10);
        hold(C_G, 9);
        hold(C_Y, 10);
        hold(C_R, 10);
        check("t4_g9_tim_cnt", n_tim - s_tim, 0);
        check("t4_g9_seq_cnt", n_seq - s_seq, 0);
        check("t4_g9_len", lens[lens.size() - 2], 9);
        hold(C_G, 12);
        {red, yellow, green} = C_Y;
        tick(2);
        check("t4_tim_g12", timing_err, 1);
        check("t4_len_g12", phase_len, 12);

        // T5: conflict during a tracked RED run
        hold(C_Y, 8);
        hold(C_R, 4);
        snap();
        {red, yellow, green} = C_RG;
        tick(2);
        check("t5_conf", conflict_err, 1);
        check("t5_phase_hold", phase, 2'b00);
        tick(1);
        hold(C_G, 3);
        check("t5_conf_cnt", n_conf - s_conf, 3);
        hold(C_Y, 10);
        {red, yellow, green} = C_R;
        tick(2);
        check("t5_done_yr", phase_done, 1);
        check("t5_tim_cnt", n_tim - s_tim, 0);
        check("t5_seq_cnt", n_seq - s_seq, 0);

        // T6: night blink, toggle precedence, illegal GREEN
        snap();
        day = 1'b0;
        hold(C_D, 5);
        hold(C_Y, 5);
        hold(C_D, 5);
        hold(C_Y, 5);
        {red, yellow, green} = C_G;
        tick(2);
        check("t6_seq_green", seq_err, 1);
        check("t6_tim_green", timing_err, 0);
        check("t6_seq_cnt", n_seq - s_seq, 1);
        check("t6_tim_cnt", n_tim - s_tim, 0);
        hold(C_G, 1);
        hold(C_D, 5);
        hold(C_Y, 3);
        day = 1'b1;
        hold(C_Y, 4);
        snap();
        {red, yellow, green} = C_D;
        tick(2);
        check("t6_toggle_tim", timing_err, 0);
        check("t6_toggle_seq", seq_err, 0);
        check("t6_toggle_len", phase_len, 7);

        // Overlong dark in day tracking flags once
        tick(13);
        {red, yellow, green} = C_R;
        tick(2);
        check("dark_done", phase_done, 1);
        check("dark_len", phase_len, 15);
        check("dark_seq", seq_err, 0);
        check("dark_tim_cnt", n_tim - s_tim, 1);
        check("dark_phase_red", phase, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
